// File: rtl/an_decoder_seq.sv
// Bit-serial AN-code single-error decoder.
// Takes a received codeword (A*N plus at most one flipped bit) and works on it
// one bit per clock. It computes the residue mod A, then looks for a single
// bit whose weight 2^i matches the residue with a consistent polarity, and
// fixes that bit. A restoring divider then recovers N. Corrected and
// uncorrectable results are tallied in saturating counters.
module an_decoder_seq #(
  parameter int A    = 61,
  parameter int AW   = 6,
  parameter int CW   = 30,
  parameter int NW   = 24,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NW-1:0]   out_data,
  output logic            out_corrected,
  output logic            out_uncorr,
  output logic [CNTW-1:0] corr_count,
  output logic [CNTW-1:0] uncorr_count
);

  localparam int            KW  = (CW > 1) ? $clog2(CW) : 1;
  localparam logic [AW-1:0] A_V = AW'(A);

  typedef enum logic [2:0] {IDLE, MOD, SRCH, DIV, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cw;         // working codeword, corrected in place
  logic [CW-1:0] quot;       // quotient shift register
  logic [AW-1:0] r;          // residue in MOD/SRCH, partial remainder in DIV
  logic [AW-1:0] p;          // 2^idx mod A during SRCH
  logic [KW-1:0] idx;        // bit index: counts down in MOD/DIV, up in SRCH
  logic [KW-1:0] pos;        // latched error position
  logic          hit;
  logic          corrected;
  logic          uncorr;

  // Reduce a value known to be below 2A into the range [0, A).
  function automatic logic [AW-1:0] reduce_mod(input logic [AW:0] t);
    if (t >= {1'b0, A_V}) reduce_mod = AW'(t - {1'b0, A_V});
    else                  reduce_mod = t[AW-1:0];
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    if (&c) sat_inc = c;
    else    sat_inc = c + CNTW'(1);
  endfunction

  logic [AW:0]   step_t;
  logic [AW-1:0] r_next;
  logic          q_bit;
  logic [AW-1:0] p_next;
  logic          match;
  logic          hit_n;
  logic [KW-1:0] pos_n;
  logic [CW-1:0] quot_n;

  // One shift-and-reduce step, shared by the residue pass and the divider.
  // Also the syndrome match for the current search index.
  always_comb begin
    step_t = {r, cw[idx]};
    r_next = reduce_mod(step_t);
    q_bit  = (step_t >= {1'b0, A_V});
    p_next = reduce_mod({p, 1'b0});
    quot_n = {quot[CW-2:0], q_bit};
    match  = (r != '0) && !hit &&
             (((r == p) && cw[idx]) || ((r == (A_V - p)) && !cw[idx]));
    hit_n  = hit | match;
    pos_n  = match ? idx : pos;
  end

  // Control FSM with the serial datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_corrected <= 1'b0;
      out_uncorr    <= 1'b0;
      corr_count    <= '0;
      uncorr_count  <= '0;
      idx           <= '0;
      hit           <= 1'b0;
      corrected     <= 1'b0;
      uncorr        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            cw        <= in_data;
            r         <= '0;
            idx       <= KW'(CW - 1);
            hit       <= 1'b0;
            corrected <= 1'b0;
            uncorr    <= 1'b0;
            in_ready  <= 1'b0;
            state     <= MOD;
          end
        end
        MOD: begin
          r <= r_next;
          if (idx == '0) begin
            idx   <= '0;
            p     <= AW'(1);
            state <= SRCH;
          end else begin
            idx <= idx - KW'(1);
          end
        end
        SRCH: begin
          hit <= hit_n;
          pos <= pos_n;
          p   <= p_next;
          if (idx == KW'(CW - 1)) begin
            if (hit_n) begin
              cw        <= cw ^ (CW'(1) << pos_n);
              corrected <= 1'b1;
            end else if (r != '0) begin
              uncorr <= 1'b1;
            end
            r     <= '0;
            idx   <= KW'(CW - 1);
            state <= DIV;
          end else begin
            idx <= idx + KW'(1);
          end
        end
        DIV: begin
          r    <= r_next;
          quot <= quot_n;
          if (idx == '0) begin
            out_valid     <= 1'b1;
            out_data      <= quot_n[NW-1:0];
            out_corrected <= corrected;
            out_uncorr    <= uncorr;
            state         <= DONE;
          end else begin
            idx <= idx - KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            if (out_corrected) corr_count   <= sat_inc(corr_count);
            if (out_uncorr)    uncorr_count <= sat_inc(uncorr_count);
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_an_decoder_seq.sv
// Testbench for an_decoder_seq: directed vector table, randomized words against
// a divisibility-based reference model, backpressure, reset abort and
// counter saturation on a narrow-counter instance.
module tb_an_decoder_seq;

  localparam int A    = 61;
  localparam int AW   = 6;
  localparam int CW   = 30;
  localparam int NW   = 24;
  localparam int CNTW = 16;
  localparam int LAT  = 3 * CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [CW-1:0]   in_data;
  logic            out_valid;
  logic            out_ready;
  logic [NW-1:0]   out_data;
  logic            out_corrected;
  logic            out_uncorr;
  logic [CNTW-1:0] corr_count;
  logic [CNTW-1:0] uncorr_count;

  logic            in_valid_s;
  logic            in_ready_s;
  logic [CW-1:0]   in_data_s;
  logic            out_valid_s;
  logic            out_ready_s;
  logic [NW-1:0]   out_data_s;
  logic            out_corrected_s;
  logic            out_uncorr_s;
  logic [1:0]      corr_count_s;
  logic [1:0]      uncorr_count_s;

  an_decoder_seq #(.A(A), .AW(AW), .CW(CW), .NW(NW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_corrected(out_corrected), .out_uncorr(out_uncorr),
    .corr_count(corr_count), .uncorr_count(uncorr_count)
  );

  an_decoder_seq #(.A(A), .AW(AW), .CW(CW), .NW(NW), .CNTW(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .out_data(out_data_s),
    .out_corrected(out_corrected_s), .out_uncorr(out_uncorr_s),
    .corr_count(corr_count_s), .uncorr_count(uncorr_count_s)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  longint exp_corr = 0;
  longint exp_unc  = 0;

  typedef struct {
    logic [CW-1:0] cw;
    logic [NW-1:0] n;
    bit            c;
    bit            u;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a single flipped bit is correctable when toggling it yields a
  // multiple of A; the lowest such bit wins.
  task automatic model(input longint cwv, output longint n, output bit c, output bit u);
    longint v;
    longint cand;
    v = cwv;
    c = 1'b0;
    u = 1'b0;
    if (cwv % A != 0) begin
      for (int i = 0; i < CW; i++) begin
        cand = cwv ^ (longint'(1) << i);
        if (!c && (cand % A == 0)) begin
          c = 1'b1;
          v = cand;
        end
      end
      u = !c;
    end
    n = (v / A) % (longint'(1) << NW);
  endtask

  task automatic send_in(input logic [CW-1:0] d);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = CW'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check("result_timeout", 0, 1);
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_word(input logic [CW-1:0] d, input logic [NW-1:0] en,
                          input bit ec, input bit eu, input string tag);
    int lat;
    send_in(d);
    wait_out(lat);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_data"}, out_data, en);
    check({tag, "_corrected"}, out_corrected, ec);
    check({tag, "_uncorr"}, out_uncorr, eu);
    take_out();
    if (ec && exp_corr < 65535) exp_corr++;
    if (eu && exp_unc < 65535)  exp_unc++;
    check({tag, "_corr_count"}, corr_count, exp_corr);
    check({tag, "_uncorr_count"}, uncorr_count, exp_unc);
    check({tag, "_in_ready_after"}, in_ready, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat;
    int            bad;
    longint        mn;
    bit            mc;
    bit            mu;
    longint        nn;
    int            mode;
    logic [CW-1:0] c;

    vt[0] = '{cw: 30'd61000,      n: 24'd1000, c: 1'b0, u: 1'b0};
    vt[1] = '{cw: 30'd60992,      n: 24'd1000, c: 1'b1, u: 1'b0};
    vt[2] = '{cw: 30'd61001,      n: 24'd1000, c: 1'b1, u: 1'b0};
    vt[3] = '{cw: 30'd60999,      n: 24'd999,  c: 1'b0, u: 1'b1};
    vt[4] = '{cw: 30'd65096,      n: 24'd1000, c: 1'b1, u: 1'b0};
    vt[5] = '{cw: 30'd0,          n: 24'd0,    c: 1'b0, u: 1'b0};
    vt[6] = '{cw: 30'd1023410176, n: 24'd0,    c: 1'b0, u: 1'b0};

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    in_valid_s  = 1'b0;
    in_data_s   = '0;
    out_ready_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_corrected", out_corrected, 0);
    check("rst_out_uncorr", out_uncorr, 0);
    check("rst_corr_count", corr_count, 0);
    check("rst_uncorr_count", uncorr_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_word(vt[i].cw, vt[i].n, vt[i].c, vt[i].u, $sformatf("vec%0d", i));
    end

    // Randomized words checked against the reference model
    for (int i = 0; i < 40; i++) begin
      nn   = longint'($urandom_range(0, 17602018));
      c    = CW'(nn * A);
      mode = $urandom_range(0, 3);
      if (mode == 1 || mode == 2) c = c ^ (CW'(1) << $urandom_range(0, CW - 1));
      if (mode == 2)              c = c ^ (CW'(1) << $urandom_range(0, CW - 1));
      if (mode == 3)              c = CW'($urandom);
      model(longint'(c), mn, mc, mu);
      run_word(c, NW'(mn), mc, mu, $sformatf("rnd%0d", i));
    end

    // Backpressure, then back-to-back acceptance on release
    send_in(30'd61000);
    wait_out(lat);
    check("bp_latency", lat, LAT);
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== 24'd1000 || in_ready !== 1'b0 ||
          out_corrected !== 1'b0 || out_uncorr !== 1'b0) bad++;
    end
    check("bp_hold_stable", bad, 0);
    in_valid  = 1'b1;
    in_data   = 30'd61000;
    take_out();
    check("bp_in_ready_u1", in_ready, 1);
    check("bp_out_valid_u1", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accepted", in_ready, 0);
    wait_out(lat);
    check("bp2_latency", lat, LAT);
    check("bp2_data", out_data, 1000);
    take_out();
    check("bp2_corr_count", corr_count, exp_corr);

    // Reset during the search phase aborts the word
    send_in(30'd60992);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_corr = 0;
    exp_unc  = 0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_corr_count", corr_count, 0);
    check("abort_uncorr_count", uncorr_count, 0);
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    check("abort_no_result", bad, 0);
    run_word(30'd61001, 24'd1000, 1'b1, 1'b0, "after_abort");

    // Saturation on the 2-bit counter instance
    for (int j = 0; j < 4; j++) begin
      int w;
      w = 0;
      in_valid_s = 1'b1;
      in_data_s  = 30'd61001;
      while (!in_ready_s && w < 400) begin
        @(posedge clk); #1;
        w++;
      end
      @(posedge clk); #1;
      in_valid_s = 1'b0;
      w = 0;
      while (!out_valid_s && w < 400) begin
        @(posedge clk); #1;
        w++;
      end
      check($sformatf("sat%0d_valid", j), out_valid_s, 1);
      check($sformatf("sat%0d_data", j), out_data_s, 1000);
      check($sformatf("sat%0d_corrected", j), out_corrected_s, 1);
      check($sformatf("sat%0d_uncorr", j), out_uncorr_s, 0);
      out_ready_s = 1'b1;
      @(posedge clk); #1;
      out_ready_s = 1'b0;
      check($sformatf("sat%0d_corr_count", j), corr_count_s, (j + 1 > 3) ? 3 : j + 1);
      check($sformatf("sat%0d_uncorr_count", j), uncorr_count_s, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/an_decoder_seq.md
# an_decoder_seq

Sequential, parametrised AN-code single-bit-error decoder with valid/ready handshakes on both sides. It accepts a CW-bit codeword (A·N plus possible error), computes the residue mod A bit-serially, and searches for a single-bit error whose syndrome matches and whose received-bit polarity is consistent. It then corrects that bit, divides by A with a serial restoring divider, and reports corrected/uncorrectable status with saturating event counters. It is the multi-cycle, low-area successor of the combinational residue-lookup decoder and sits between the protected datapath and the consumer of N.

## Interface
- A, 61: code constant; odd, ≥3.
- AW, 6: residue width; must satisfy 2^AW > A.
- CW, 30: codeword width.
- NW, 24: decoded data width.
- CNTW, 16: event counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  codeword valid.
- in_ready  out  1  decoder can accept.
- in_data  in  CW  received codeword.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  NW  decoded N.
- out_corrected  out  1  one bit was corrected.
- out_uncorr  out  1  nonzero residue, no consistent single-bit match.
- corr_count  out  CNTW  saturating count of corrected results.
- uncorr_count  out  CNTW  saturating count of uncorrectable results.

## Operation
- States: IDLE, MOD, SRCH, DIV, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE: on in_valid && in_ready, latch in_data into cw, clear r, set bit index k=CW-1, then go to MOD.
- MOD (CW cycles, MSB first): r ← 2r + cw[k]; if the result is ≥ A, subtract A. Width of the intermediate is AW+1. After bit 0, go to SRCH with i=0 and p=1 (p = 2^i mod A).
- SRCH (CW cycles, i = 0..CW-1):
  - If r ≠ 0, no match has yet been latched, and either (r==p and cw[i]==1) or (r==A−p and cw[i]==0), latch pos=i and hit=1.
  - p ← 2p; if the result is ≥ A, subtract A.
  - The lowest matching index wins; later matches are ignored.
  - If r==0, no match is ever latched.
- End of SRCH:
  - If hit, flip cw[pos] and set corrected=1.
  - If r≠0 and !hit, set uncorr=1 and leave cw unchanged.
  - Go to DIV.
- DIV (CW cycles): restoring division of cw by A, MSB first; partial remainder AW+1 bits.
- DONE: out_data = quotient[NW-1:0] (upper quotient bits are dropped); out_corrected and out_uncorr come from the flags.
  - On out_ready, return to IDLE.
  - On that same handshake cycle, corr_count increments if corrected, and uncorr_count increments if uncorr. Both saturate at all-ones.
- out_corrected and out_uncorr are never both 1.
- Residue 0 gives out_corrected=0 and out_uncorr=0.
- Inputs are ignored outside the IDLE handshake. in_data may change freely after acceptance.

## Timing
- Reset values:
  - state=IDLE, in_ready=1 (from the cycle after rst is sampled).
  - out_valid=0, out_data=0, out_corrected=0, out_uncorr=0.
  - corr_count=0, uncorr_count=0.
- rst asserted mid-operation (any state) aborts the operation. Counters clear and no result is emitted.
- Fixed latency. If the input handshake happens at cycle T:
  - MOD covers T+1..T+CW.
  - SRCH covers T+CW+1..T+2CW.
  - DIV covers T+2CW+1..T+3CW.
  - out_valid is high from T+3CW+1. With defaults, that is T+91.
- out_valid and the out_* data are held stable until out_ready is sampled high (backpressure is unlimited).
- If the output handshake happens at cycle U, in_ready=1 at U+1. Back-to-back throughput is one codeword per 3CW+2 cycles.
- Counters update at U+1, i.e., visible the cycle after the output handshake.

## Test plan
- Clean codeword: in_data=61000 (A·1000) → out_data=1000, out_corrected=0, out_uncorr=0; out_valid exactly 91 cycles after the input handshake.
- 1→0 error, bit 3: in_data=60992 (residue 53 = 61−8, received bit3=0) → out_data=1000, out_corrected=1, corr_count=1.
- 0→1 error, bit 0: in_data=61001 (residue 1, received bit0=1) → out_data=1000, out_corrected=1.
- Uncorrectable: in_data=60999 (residue 60; no i<30 has 2^i≡±1 mod 61 with a consistent bit polarity except i=0, whose polarity is wrong) → out_data=999, out_uncorr=1, uncorr_count=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 20 cycles → outputs stay stable and in_ready stays 0.
  - Release out_ready → second codeword 61000 is accepted at U+1 and its result appears at U+1+91.
- Reset mid-SRCH, then saturation:
  - Assert rst during SRCH → next cycle in_ready=1, out_valid=0, counters=0.
  - With CNTW=2, run 4 corrected words → corr_count stays at 3.
